// File: rtl/dmem_responder_if.sv
// Request/response bus between the core memory stage (master) and the
// data-memory responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. A source holds its valid and
// payload stable until the transfer; valid never waits on ready.
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word-aligned load/store at a time,
// waits a fixed LATENCY, commits the access to on-chip word RAM on the edge
// entering RESP, and holds the response until the consumer takes it.
// Optional fault checking (misaligned / out-of-range) is enabled by the
// DMEM_ERR_CHECK_EN macro; without it the word index wraps modulo DEPTH.
module dmem_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state
);
    localparam int NB = XLEN / 8;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            enter_resp;

    // Latched request; only meaningful once the request has been accepted.
    logic            a_write;
    logic [XLEN-1:0] a_addr;
    logic [XLEN-1:0] a_wdata;
    logic [NB-1:0]   a_wstrb;

    // In IDLE the access in flight is the one on the bus right now (needed
    // when LATENCY == 1 commits on the accept edge itself).
    logic            cur_write;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [NB-1:0]   cur_wstrb;
    logic [IW-1:0]   cur_idx;
    logic            fault;

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata;

    assign cur_write = (state == IDLE) ? bus.req_write : a_write;
    assign cur_addr  = (state == IDLE) ? bus.req_addr  : a_addr;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : a_wdata;
    assign cur_wstrb = (state == IDLE) ? bus.req_wstrb : a_wstrb;
    assign cur_idx   = cur_addr[IW+1:2];

    // Byte offset and high address bits feed only the optional fault check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_addr[1:0], cur_addr[XLEN-1:IW+2]};

`ifdef DMEM_ERR_CHECK_EN
    assign fault = (cur_addr[1:0] != 2'b00) || ((cur_addr >> 2) >= XLEN'(DEPTH));
`else
    assign fault = 1'b0;
`endif

    assign enter_resp     = (state != RESP) && (state_next == RESP);
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata;
    assign dbg_state      = state;

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CW'(1)) state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latency counter and response data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.req_valid)
                cnt <= CW'(LATENCY - 1);
            else if (state == WAIT)
                cnt <= cnt - CW'(1);
            if (enter_resp)
                rdata <= (cur_write || fault) ? '0 : mem[cur_idx];
        end
    end

    // Capture the request on acceptance; the bus is don't-care afterwards.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            a_write <= bus.req_write;
            a_addr  <= bus.req_addr;
            a_wdata <= bus.req_wdata;
            a_wstrb <= bus.req_wstrb;
        end
    end

    // Byte-strobed store commit; a reset on the same edge abandons it.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_write && !fault) begin
            for (int i = 0; i < NB; i++) begin
                if (cur_wstrb[i])
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic err;

    // Fault flag captured alongside the response data.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (enter_resp)
            err <= fault;
    end

    assign bus.resp_err = err;
`else
    assign bus.resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance exercises
// stores, loads, byte strobes, backpressure, address wrap (or faults when
// DMEM_ERR_CHECK_EN is defined) and reset in WAIT/RESP; a LATENCY=1
// instance checks single-cycle latency and back-to-back acceptance.
module tb_dmem_responder;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;
    int checks = 0;
    int errors = 0;
    logic [31:0] w0_exp;

    always #5 clk = ~clk;

    dmem_responder_if #(.XLEN(XLEN)) bus ();
    dmem_responder_if #(.XLEN(XLEN)) bus1 ();

    dmem_responder #(.XLEN(XLEN), .DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state(dbg_state)
    );

    dmem_responder #(.XLEN(XLEN), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(dbg_state1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom_range(0, 15));
    endtask

    // Full request/response on the LATENCY=2 instance with resp_ready high.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string tag,
                            input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_wstrb  = s;
        bus.resp_ready = 1'b1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble_req();
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        chk({tag, "_ready_in_resp"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        logic [31:0] held;

        reset = 1'b1;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = '0;
        bus.req_wdata = '0;    bus.req_wstrb = '0;    bus.resp_ready = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.req_wstrb = '0;   bus1.resp_ready = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst1_idle", {30'd0, bus1.req_ready, bus1.resp_valid}, 32'b10);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);

        // Full-word store then load.
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_full", 32'h0, 1'b0);
        transact(1'b0, 32'h10, 32'h0, 4'h0, "ld_full", 32'hDEADBEEF, 1'b0);

        // Single-byte store merges into the existing word.
        transact(1'b1, 32'h10, 32'h000000AA, 4'h1, "st_byte0", 32'h0, 1'b0);
        transact(1'b0, 32'h10, 32'h0, 4'h0, "ld_byte0", 32'hDEADBEAA, 1'b0);

        // Upper-half store on another word, then zero-strobe store.
        transact(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, "st_w5", 32'h0, 1'b0);
        transact(1'b1, 32'h14, 32'h1234ABCD, 4'hC, "st_hi", 32'h0, 1'b0);
        transact(1'b0, 32'h14, 32'h0, 4'h0, "ld_hi", 32'h1234FFFF, 1'b0);
        transact(1'b1, 32'h10, 32'h55555555, 4'h0, "st_nostrb", 32'h0, 1'b0);
        transact(1'b0, 32'h10, 32'h0, 4'h0, "ld_nostrb", 32'hDEADBEAA, 1'b0);

        // Known content for word 0 and word 8.
        transact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, "st_w0", 32'h0, 1'b0);
        transact(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, "st_w8", 32'h0, 1'b0);

`ifdef DMEM_ERR_CHECK_EN
        transact(1'b1, 32'h402, 32'h12345678, 4'hF, "err_misaligned", 32'h0, 1'b1);
        transact(1'b1, 32'h400, 32'h12345678, 4'hF, "err_range", 32'h0, 1'b1);
        transact(1'b0, 32'h0, 32'h0, 4'h0, "err_ram_kept", 32'h0BADF00D, 1'b0);
        transact(1'b0, 32'h402, 32'h0, 4'h0, "err_ld_misaligned", 32'h0, 1'b1);
        w0_exp = 32'h0BADF00D;
`else
        transact(1'b1, 32'h400, 32'h12345678, 4'hF, "wrap_st", 32'h0, 1'b0);
        transact(1'b0, 32'h0, 32'h0, 4'h0, "wrap_ld", 32'h12345678, 1'b0);
        w0_exp = 32'h12345678;
`endif

        // Backpressure: response held, a competing request is not taken.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 32'(n), 32'd2);
        held = 32'hDEADBEAA;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid_held", 32'(bus.resp_valid), 32'd1);
            chk("bp_rdata_held", bus.resp_rdata, held);
            chk("bp_req_blocked", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_second_accepted", 32'(dbg_state), 32'd1);
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_latency", 32'(n), 32'd2);
        chk("bp_second_rdata", bus.resp_rdata, w0_exp);
        @(negedge clk);

        // Reset in WAIT abandons the store.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h11111111; bus.req_wstrb = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rw_in_wait", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_idle", {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_resp", 32'(bus.resp_valid), 32'd0);
            @(negedge clk);
        end
        transact(1'b0, 32'h20, 32'h0, 4'h0, "rw_ld", 32'hCAFEF00D, 1'b0);

        // Reset in RESP drops the response but the store stands.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h24;
        bus.req_wdata = 32'h5A5A5A5A; bus.req_wstrb = 4'hF; bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rr_in_resp", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.resp_ready = 1'b1;
        chk("rr_dropped", {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
        chk("rr_rdata_cleared", bus.resp_rdata, 32'h0);
        transact(1'b0, 32'h24, 32'h0, 4'h0, "rr_ld", 32'h5A5A5A5A, 1'b0);

        // LATENCY=1 instance: store, then back-to-back loads.
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 32'h8;
        bus1.req_wdata = 32'hA5A50F0F; bus1.req_wstrb = 4'hF; bus1.resp_ready = 1'b1;
        chk("l1_st_ready", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk("l1_st_resp", {30'd0, bus1.resp_valid, bus1.req_ready}, 32'b10);
        chk("l1_st_rdata", bus1.resp_rdata, 32'h0);
        @(negedge clk);
        chk("l1_st_done", {30'd0, bus1.resp_valid, bus1.req_ready}, 32'b01);
        bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 32'h8;
        for (int i = 0; i < 6; i++) begin
            chk("l1_b2b_ready", 32'(bus1.req_ready), 32'((i % 2) == 0));
            chk("l1_b2b_valid", 32'(bus1.resp_valid), 32'((i % 2) == 1));
            if ((i % 2) == 1)
                chk("l1_b2b_rdata", bus1.resp_rdata, 32'hA5A50F0F);
            @(negedge clk);
        end
        bus1.req_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder: the memory-side end of the core's load/store request interface.
- Accepts one word-aligned request at a time over a valid/ready handshake.
- Models a fixed access latency, applies byte-strobed writes, and returns read data or a completion over a valid/ready response channel.
- Sits between the core's memory stage and on-chip word RAM; replaces the zero-latency memory in multi-cycle and stall testing.

Parameters:
XLEN, 32, data/address width (matches ISA word width)
DEPTH, 256, number of XLEN-bit words; power of two, >= 2
LATENCY, 2, cycles from request acceptance to first resp_valid; >= 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data
req_wstrb  input  XLEN/8  byte enables for store; bit i covers bits [8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  XLEN  load data; 0 for stores and errored accesses
resp_err  output  1  access faulted (see Optional Feature)

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- States: IDLE, WAIT, RESP. One outstanding request maximum.
- req_ready = (state == IDLE), decoded combinationally from state.
- Accept: req_valid && req_ready in cycle c. Latch write, addr, wdata, wstrb; req_* is don't-care afterwards.
- LATENCY == 1: IDLE -> RESP at end of cycle c.
- LATENCY > 1: IDLE -> WAIT with cnt = LATENCY-1. WAIT decrements cnt each cycle; at cnt == 1, WAIT -> RESP.
- resp_valid is first high in cycle c+LATENCY.
- Access commits on the edge entering RESP:
  - Store: for each set wstrb bit, write that byte of word index addr[XLEN-1:2]; other bytes unchanged. resp_rdata = 0.
  - Load: resp_rdata = full word at that index.
  - wstrb = 0 on a store: no change; still completes normally.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready, then goes to IDLE next cycle.
- req_ready stays 0 throughout RESP, including the handshake cycle. Minimum request spacing = LATENCY+1 cycles.
- Load after store to the same address returns the stored data, since the store has committed before its response.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, cnt 0.
- RAM contents are not reset.
- Reset during WAIT: request abandoned; store not committed.
- Reset during RESP: response dropped; store already committed.
- req_valid while not ready: ignored; no latch and no side effects.

Optional Feature:
Macro DMEM_ERR_CHECK_EN.
- Defined: fault if addr[1:0] != 0 or (addr >> 2) >= DEPTH.
  - Faulted access: resp_err = 1, resp_rdata = 0, store suppressed (RAM unchanged).
  - Latency and handshake identical to a normal access.
- Undefined:
  - resp_err tied 0.
  - addr[1:0] ignored.
  - Word index = (addr >> 2) mod DEPTH, i.e. wraps.

Test Plan:
- Reset, then idle: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Assert reset mid-WAIT -> IDLE next cycle, resp_valid never rises.
- Store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, accepted cycle 5 (LATENCY=2) -> resp_valid high cycle 7, resp_rdata 0, req_ready 0 cycles 6-7. Then load 0x10 -> resp_rdata 0xDEADBEEF.
- Partial store 0x10, wdata 0x000000AA, wstrb 0x1 over 0xDEADBEEF -> subsequent load returns 0xDEADBEAA.
- Backpressure: load held with resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stable all 4 cycles. req_valid asserted meanwhile is not accepted; accepted only once IDLE is re-entered.
- Error (DMEM_ERR_CHECK_EN): store 0x402 (misaligned), then store 0x400 (index 256 >= DEPTH), each wstrb 0xF -> resp_err=1, resp_rdata 0, RAM unchanged. Without macro: store 0x400 wdata 0x12345678 lands in word 0; load 0x0 returns 0x12345678.
- LATENCY=1 build: load accepted cycle 3 -> resp_valid cycle 4. Back-to-back loads with resp_ready=1 -> accepted every 2 cycles.
